// File: rtl/que_slot_pkg.sv
// Shared types and defaults for the switch queue slot receive handler.
package que_slot_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADVERTISE = 2'd1,
        S_STREAM    = 2'd2,
        S_DRAIN     = 2'd3
    } state_type;

    localparam int unsigned QS_DATA_WIDTH = 8;

    typedef struct packed {
        logic                     first;
        logic [QS_DATA_WIDTH-1:0] data;
    } push_word_t;

    localparam logic [15:0] QS_TIMEOUT_DEFAULT = 16'h8;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; o_expired is high once the count has reached zero.
module cycle_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/que_slot_skid_buffer.sv
// Small FIFO absorbing words while the fabric stalls; a push is accepted when
// full provided the head is popped in the same cycle.
module que_slot_skid_buffer #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/que_slot_stream_receiver.sv
// Receive handler for one switch queue slot: advertises a good packet, then
// streams it to the fabric push port through a skid buffer with first-word tag.
module que_slot_stream_receiver
    import que_slot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned SKID_DEPTH    = 4,
    parameter logic [15:0] TIMEOUT_LIMIT = QS_TIMEOUT_DEFAULT,
    parameter int unsigned LENGTH_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    data_enable,
    input  logic                    good_packet,
    input  logic                    bad_packet,
    input  logic                    push_data_enable,
    output logic                    fifo_reset_n,
    output logic                    ready,
    output logic                    push_data_ready,
    output logic [DATA_WIDTH:0]     push_data,
    output logic                    push_data_valid,
    output logic                    packet_done,
    output logic [LENGTH_WIDTH-1:0] packet_length,
    output logic                    overflow_event
);

    state_type               r_state;
    state_type               w_next_state;
    logic                    r_first;
    logic [LENGTH_WIDTH-1:0] r_length;
    logic                    r_fifo_reset_n;
    logic                    r_ready;
    logic                    r_push_data_ready;
    logic                    r_push_first;
    logic [DATA_WIDTH-1:0]   r_push_word;
    logic                    r_push_valid;
    logic                    r_packet_done;
    logic [LENGTH_WIDTH-1:0] r_packet_length;
    logic                    r_overflow;

    logic                    w_go;
    logic                    w_streaming;
    logic                    w_direct;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_emit;
    logic                    w_drain_done;
    logic                    w_load;
    logic                    w_expired;
    logic                    w_full;
    logic                    w_empty;
    logic [DATA_WIDTH-1:0]   w_head;
    logic [DATA_WIDTH-1:0]   w_emit_word;

    // Direct path bypasses the skid only when nothing older is queued, keeping FIFO order.
    always_comb begin
        w_go         = enable & push_data_enable;
        w_streaming  = (r_state == S_STREAM);
        w_pop        = w_go & ~w_empty & ((r_state == S_STREAM) | (r_state == S_DRAIN));
        w_direct     = w_streaming & data_enable & w_go & w_empty;
        w_push       = w_streaming & data_enable & ~w_direct & (~w_full | w_pop);
        w_drop       = w_streaming & data_enable & ~w_direct & w_full & ~w_pop;
        w_emit       = w_direct | w_pop;
        w_emit_word  = w_direct ? data : w_head;
        w_drain_done = (r_state == S_DRAIN) & w_empty;
        w_load       = ~w_streaming | data_enable;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (!bad_packet && good_packet) w_next_state = S_ADVERTISE;
            S_ADVERTISE: if (w_go)                       w_next_state = S_STREAM;
            S_STREAM:    if (w_expired)                  w_next_state = S_DRAIN;
            S_DRAIN:     if (w_empty)                    w_next_state = S_IDLE;
            default:                                     w_next_state = S_IDLE;
        endcase
    end

    que_slot_skid_buffer #(
        .DW    (DATA_WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .i_clock     (clock),
        .i_reset_n   (reset_n),
        .i_push      (w_push),
        .i_push_data (data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    cycle_timer #(
        .WIDTH (16)
    ) u_timer (
        .i_clock      (clock),
        .i_reset_n    (reset_n),
        .i_load       (w_load),
        .i_load_value (TIMEOUT_LIMIT),
        .o_expired    (w_expired)
    );

    // ready stays high through drain so the arbiter keeps granting until empty.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_first           <= 1'b1;
            r_length          <= '0;
            r_fifo_reset_n    <= 1'b0;
            r_ready           <= 1'b0;
            r_push_data_ready <= 1'b0;
            r_push_first      <= 1'b0;
            r_push_word       <= '0;
            r_push_valid      <= 1'b0;
            r_packet_done     <= 1'b0;
            r_packet_length   <= '0;
            r_overflow        <= 1'b0;
        end else begin
            r_state           <= w_next_state;
            r_fifo_reset_n    <= ~((r_state == S_IDLE) & bad_packet);
            r_ready           <= (w_next_state != S_IDLE);
            r_push_data_ready <= w_go & (r_state != S_IDLE);
            r_push_valid      <= w_emit;
            r_overflow        <= w_drop;
            r_packet_done     <= w_drain_done;
            if (w_drain_done) r_packet_length <= r_length;
            if (w_emit) begin
                r_push_first <= r_first;
                r_push_word  <= w_emit_word;
            end
            if (r_state == S_IDLE) begin
                r_first  <= 1'b1;
                r_length <= '0;
            end else if (w_emit) begin
                r_first <= 1'b0;
                if (r_length != '1) r_length <= r_length + 1'b1;
            end
        end
    end

    assign fifo_reset_n    = r_fifo_reset_n;
    assign ready           = r_ready;
    assign push_data_ready = r_push_data_ready;
    assign push_data       = {r_push_first, r_push_word};
    assign push_data_valid = r_push_valid;
    assign packet_done     = r_packet_done;
    assign packet_length   = r_packet_length;
    assign overflow_event  = r_overflow;

endmodule

// File: tb/tb_que_slot_stream_receiver.sv
// Scoreboard bench for que_slot_stream_receiver: expected beats are queued as
// words are driven and compared as the push port produces them.
module tb_que_slot_stream_receiver;
    import que_slot_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [DW-1:0] data;
    logic          data_enable;
    logic          good_packet;
    logic          bad_packet;
    logic          push_data_enable;
    logic          fifo_reset_n;
    logic          ready;
    logic          push_data_ready;
    logic [DW:0]   push_data;
    logic          push_data_valid;
    logic          packet_done;
    logic [LW-1:0] packet_length;
    logic          overflow_event;

    always #5 clock = ~clock;

    que_slot_stream_receiver #(
        .DATA_WIDTH    (DW),
        .SKID_DEPTH    (DEPTH),
        .TIMEOUT_LIMIT (16'h8),
        .LENGTH_WIDTH  (LW)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .data             (data),
        .data_enable      (data_enable),
        .good_packet      (good_packet),
        .bad_packet       (bad_packet),
        .push_data_enable (push_data_enable),
        .fifo_reset_n     (fifo_reset_n),
        .ready            (ready),
        .push_data_ready  (push_data_ready),
        .push_data        (push_data),
        .push_data_valid  (push_data_valid),
        .packet_done      (packet_done),
        .packet_length    (packet_length),
        .overflow_event   (overflow_event)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    push_word_t sb[$];
    int         m_occ;
    int         m_len;
    int         m_drops;
    int         ovf_seen;
    bit         m_active;
    bit         done_seen;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_exp(input logic [DW-1:0] w);
        push_word_t e;
        e.first = (m_len == 0);
        e.data  = w;
        sb.push_back(e);
        m_len++;
    endfunction

    // Drives one cycle and advances the occupancy model of the skid buffer.
    task automatic cyc(input bit de, input logic [DW-1:0] w, input bit pde);
        int o;
        bit pop;
        bit ins;
        data_enable      = de;
        data             = w;
        push_data_enable = pde;
        o   = m_occ;
        pop = pde && (o > 0);
        ins = 1'b0;
        if (de && m_active) begin
            if (pde && o == 0) push_exp(w);
            else if (o < int'(DEPTH) || pop) begin
                push_exp(w);
                ins = 1'b1;
            end else m_drops++;
        end
        m_occ = o - int'(pop) + int'(ins);
        @(posedge clock);
        #1;
    endtask

    task automatic start_packet();
        m_len = 0; m_drops = 0; ovf_seen = 0; done_seen = 1'b0; m_occ = 0; m_active = 1'b0;
        good_packet = 1'b1;
        cyc(1'b0, '0, 1'b1);
        good_packet = 1'b0;
        for (int i = 0; i < 8 && !push_data_ready; i++) cyc(1'b0, '0, 1'b1);
        check_value("stream_start", {31'd0, push_data_ready}, 32'd1);
        check_value("ready_streaming", {31'd0, ready}, 32'd1);
        m_active = 1'b1;
    endtask

    task automatic finish_packet(input string tag);
        m_active = 1'b0;
        for (int i = 0; i < 60 && !done_seen; i++) cyc(1'b0, '0, 1'b1);
        check_value({tag, "_done"}, {31'd0, done_seen}, 32'd1);
        check_value({tag, "_overflow"}, ovf_seen, m_drops);
        cyc(1'b0, '0, 1'b1);
        check_value({tag, "_idle_ready"}, {31'd0, ready}, 32'd0);
    endtask

    always @(negedge clock) begin
        if (push_data_valid) begin
            logic [DW:0] e;
            check_value("beat_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_value("beat", push_data, e);
            end
        end
        if (overflow_event) ovf_seen++;
        if (packet_done) begin
            check_value("packet_length", packet_length, m_len);
            check_value("sb_drained", sb.size(), 0);
            done_seen = 1'b1;
        end
    end

    task automatic check_all_zero(input string tag);
        check_value({tag, "_push_data"}, push_data, 0);
        check_value({tag, "_outputs"},
                    {26'd0, fifo_reset_n, ready, push_data_ready, push_data_valid,
                     packet_done, overflow_event}, 0);
        check_value({tag, "_length"}, packet_length, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; enable = 1'b1; data = '0; data_enable = 1'b0;
        good_packet = 1'b0; bad_packet = 1'b0; push_data_enable = 1'b1;
        m_occ = 0; m_len = 0; m_drops = 0; ovf_seen = 0; m_active = 1'b0; done_seen = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        cyc(1'b0, '0, 1'b1);
        check_value("fifo_reset_n_idle", {31'd0, fifo_reset_n}, 32'd1);

        // 1: straight-through packet
        start_packet();
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'h10 + DW'(i), 1'b1);
        finish_packet("t1");

        // 2: short stall, nothing lost
        start_packet();
        cyc(1'b1, 8'h20, 1'b1);
        cyc(1'b1, 8'hA1, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0);
        finish_packet("t2");

        // 3: long stall overflows the skid
        start_packet();
        cyc(1'b1, 8'h30, 1'b1);
        cyc(1'b1, 8'h31, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'h32 + DW'(i), 1'b0);
        finish_packet("t3");

        // 4: bad packet flushes upstream FIFO, alone and with good
        for (int k = 0; k < 2; k++) begin
            bad_packet  = 1'b1;
            good_packet = (k == 1);
            cyc(1'b0, '0, 1'b1);
            bad_packet = 1'b0; good_packet = 1'b0;
            check_value("t4_flush_low", {31'd0, fifo_reset_n}, 32'd0);
            check_value("t4_ready_low", {31'd0, ready}, 32'd0);
            cyc(1'b0, '0, 1'b1);
            check_value("t4_flush_high", {31'd0, fifo_reset_n}, 32'd1);
            check_value("t4_ready_still_low", {31'd0, ready}, 32'd0);
        end

        // 5: timeout with two queued words, drain only once go returns
        start_packet();
        cyc(1'b1, 8'h50, 1'b0);
        cyc(1'b1, 8'h51, 1'b0);
        repeat (12) cyc(1'b0, '0, 1'b0);
        m_active = 1'b0;
        cyc(1'b1, 8'hEE, 1'b0);
        check_value("t5_no_done_while_stalled", {31'd0, done_seen}, 32'd0);
        finish_packet("t5");

        // 7: push accepted when full because the head pops the same cycle
        start_packet();
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h70 + DW'(i), 1'b0);
        cyc(1'b1, 8'h74, 1'b1);
        finish_packet("t7");

        // 6: reset mid-stream abandons the packet
        start_packet();
        cyc(1'b1, 8'h60, 1'b1);
        cyc(1'b1, 8'h61, 1'b1);
        reset_n = 1'b0;
        cyc(1'b0, '0, 1'b1);
        check_all_zero("t6_reset");
        check_value("t6_sb_empty", sb.size(), 0);
        reset_n = 1'b1;
        m_occ = 0;
        cyc(1'b0, '0, 1'b1);
        start_packet();
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h80 + DW'(i), 1'b1);
        finish_packet("t6_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
